// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC, instruction register, next-PC selection, misalignment fault
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemData,
  input  logic        stall,
  input  logic        branch,
  input  logic        PC_Source,
  input  logic        contJAL,
  input  logic        contJALR,
  input  logic        branchCond,
  input  logic [31:0] imm,
  input  logic [31:0] rs1Data,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        instrValid,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4,
  output logic        misaligned
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ISSUE, S_HALT} state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic        r_misaligned;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_plus_imm;
  logic [31:0] w_jalr_tgt;
  logic [31:0] w_next_pc;
  logic        w_ld_ir;
  logic        w_ld_pc;
  logic        w_set_fault;

  assign w_pc_plus4    = r_pc + 32'd4;
  assign w_pc_plus_imm = r_pc + imm;
  assign w_jalr_tgt    = (rs1Data + imm) & 32'hFFFF_FFFE;

  // JAL raises both contJAL and contJALR, so contJAL must be tested first.
  always_comb begin
    w_next_pc = w_pc_plus4;
    if (PC_Source && contJAL)
      w_next_pc = w_pc_plus_imm;
    else if (PC_Source && contJALR)
      w_next_pc = w_jalr_tgt;
    else if (branch && branchCond)
      w_next_pc = w_pc_plus_imm;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ld_ir     = 1'b0;
    w_ld_pc     = 1'b0;
    w_set_fault = 1'b0;
    imemReq     = 1'b0;
    instrValid  = 1'b0;
    case (r_state)
      S_IDLE: w_state_nxt = S_REQ;
      S_REQ: begin
        imemReq = 1'b1;
        if (imemAck) begin
          w_ld_ir     = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        instrValid = 1'b1;
        if (!stall) begin
          if (w_next_pc[1:0] != 2'b00) begin
            w_set_fault = 1'b1;
            w_state_nxt = S_HALT;
          end else begin
            w_ld_pc     = 1'b1;
            w_state_nxt = S_REQ;
          end
        end
      end
      S_HALT: w_state_nxt = S_HALT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_ir         <= NOP;
      r_misaligned <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ld_ir)     r_ir         <= imemData;
      if (w_ld_pc)     r_pc         <= w_next_pc;
      if (w_set_fault) r_misaligned <= 1'b1;
    end
  end

  assign imemAddr   = r_pc;
  assign pc         = r_pc;
  assign pcPlus4    = w_pc_plus4;
  assign misaligned = r_misaligned;
  assign opcode     = r_ir[6:0];
  assign rd         = r_ir[11:7];
  assign funct3     = r_ir[14:12];
  assign rs1        = r_ir[19:15];
  assign rs2        = r_ir[24:20];
  assign funct7     = r_ir[31:25];

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemData;
  logic        stall, branch, PC_Source, contJAL, contJALR, branchCond;
  logic [31:0] imm, rs1Data;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic        instrValid;
  logic [31:0] pc, pcPlus4;
  logic        misaligned;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .imemReq(imemReq), .imemAddr(imemAddr),
    .imemAck(imemAck), .imemData(imemData), .stall(stall), .branch(branch),
    .PC_Source(PC_Source), .contJAL(contJAL), .contJALR(contJALR),
    .branchCond(branchCond), .imm(imm), .rs1Data(rs1Data),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1),
    .rs2(rs2), .instrValid(instrValid), .pc(pc), .pcPlus4(pcPlus4),
    .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_ctrl();
    stall = 0; branch = 0; PC_Source = 0; contJAL = 0; contJALR = 0;
    branchCond = 0; imm = 0; rs1Data = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    imemAck = 0;
    clear_ctrl();
    repeat (2) @(negedge clk);
    check("rst_req", 32'(imemReq), 32'd0);
    check("rst_valid", 32'(instrValid), 32'd0);
    check("rst_misal", 32'(misaligned), 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_ir_nop", 32'({funct7, rs2, rs1, funct3, rd, opcode}), 32'h0000_0013);
    rst_n = 1;
    exp_q.delete();
    exp_q.push_back(32'h0);
  endtask

  task automatic wait_req();
    int waited = 0;
    while (!imemReq && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("req_seen", 32'(imemReq), 32'd1);
  endtask

  // Serve one fetch with 'delay' wait cycles, stall 'stalls' cycles in issue,
  // then release with the given control inputs; exp_next is the expected next PC.
  task automatic do_fetch(input logic [31:0] data, input int delay, input int stalls,
                          input logic br, input logic bc, input logic pcs,
                          input logic cj, input logic cjr,
                          input logic [31:0] im, input logic [31:0] r1,
                          input logic [31:0] exp_next);
    logic [31:0] exp_addr;
    int req_cycles = 0;
    wait_req();
    exp_addr = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check("fetch_addr", imemAddr, exp_addr);
    for (int i = 0; i < delay; i++) begin
      req_cycles += int'(imemReq);
      @(negedge clk);
    end
    req_cycles += int'(imemReq);
    imemAck = 1;
    imemData = data;
    @(negedge clk);
    imemAck = 0;
    imemData = $urandom;
    if (delay > 0) check("req_held", 32'(req_cycles), 32'(delay + 1));
    check("issue_valid", 32'(instrValid), 32'd1);
    check("issue_req", 32'(imemReq), 32'd0);
    check("issue_opcode", 32'(opcode), 32'(data[6:0]));
    check("issue_rd", 32'(rd), 32'(data[11:7]));
    check("issue_pc", pc, exp_addr);
    check("issue_pc4", pcPlus4, exp_addr + 32'd4);
    for (int i = 0; i < stalls; i++) begin
      stall = 1;
      @(negedge clk);
      check("stall_valid", 32'(instrValid), 32'd1);
      check("stall_pc", pc, exp_addr);
      check("stall_ir", {funct7, rs2, rs1, funct3, rd, opcode}, data);
    end
    stall = 0; branch = br; branchCond = bc; PC_Source = pcs;
    contJAL = cj; contJALR = cjr; imm = im; rs1Data = r1;
    if (exp_next[1:0] == 2'b00) exp_q.push_back(exp_next);
    @(negedge clk);
    clear_ctrl();
    if (exp_next[1:0] != 2'b00) begin
      check("fault_misal", 32'(misaligned), 32'd1);
      check("fault_pc", pc, exp_addr);
      for (int i = 0; i < 4; i++) begin
        imemAck = 1;
        check("halt_req", 32'(imemReq), 32'd0);
        check("halt_valid", 32'(instrValid), 32'd0);
        @(negedge clk);
      end
      imemAck = 0;
      check("halt_misal", 32'(misaligned), 32'd1);
    end else begin
      check("no_misal", 32'(misaligned), 32'd0);
    end
  endtask

  initial begin
    imemData = 0;
    @(negedge clk);
    do_reset();
    @(negedge clk);
    check("req_cycle1", 32'(imemReq), 32'd1);
    // plain fetch with immediate ack
    do_fetch(32'h0010_0093, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h4);
    // delayed ack and stall
    do_fetch(32'h0020_8113, 3, 2, 0, 0, 0, 0, 0, 0, 0, 32'h8);
    do_fetch(32'h0000_0013, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'hC);
    do_fetch(32'h0000_0013, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h10);
    // JAL at 0x10
    do_fetch(32'h0200_00EF, 0, 0, 0, 0, 1, 1, 1, 32'h20, 32'h0, 32'h30);
    do_fetch(32'h0000_0463, 0, 0, 1, 1, 0, 0, 0, 32'h10, 0, 32'h40);
    // BNE taken / not taken at 0x40
    do_fetch(32'hFE20_9CE3, 0, 0, 1, 1, 0, 0, 0, 32'hFFFF_FFF8, 0, 32'h38);
    do_fetch(32'h0000_0013, 0, 0, 1, 0, 0, 0, 0, 32'h20, 0, 32'h3C);
    do_fetch(32'h0000_0013, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h40);
    do_fetch(32'hFE20_9CE3, 0, 0, 1, 0, 0, 0, 0, 32'hFFFF_FFF8, 0, 32'h44);
    // JALR clears bit 0; JALR outranks a taken branch
    do_fetch(32'h0000_8067, 0, 0, 0, 0, 1, 0, 1, 32'h0, 32'h101, 32'h100);
    do_fetch(32'h0080_8067, 2, 0, 1, 1, 1, 0, 1, 32'h8, 32'h200, 32'h208);
    // wrap past the top of the address space
    do_fetch(32'h0000_8067, 0, 0, 0, 0, 1, 0, 1, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    do_fetch(32'h0000_0013, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    // misaligned JALR target halts the unit
    do_fetch(32'h0000_8067, 0, 0, 0, 0, 1, 0, 1, 32'h0, 32'h102, 32'h102);

    // reset during REQ discards a coincident ack
    do_reset();
    wait_req();
    imemAck = 1;
    imemData = 32'h0010_0093;
    rst_n = 0;
    @(negedge clk);
    imemAck = 0;
    check("rreq_ir_nop", {funct7, rs2, rs1, funct3, rd, opcode}, 32'h0000_0013);
    check("rreq_valid", 32'(instrValid), 32'd0);
    check("rreq_req", 32'(imemReq), 32'd0);
    check("rreq_pc", pc, 32'h0);
    rst_n = 1;
    exp_q.delete();
    exp_q.push_back(32'h0);
    do_fetch(32'h0010_0093, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h4);
    wait_req();
    check("sb_drain", exp_q.size() > 0 ? exp_q.pop_front() : 32'hDEAD_BEEF, imemAddr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 imemReq  output  1  instruction-memory read request.
REQ-005 imemAddr  output  32  instruction-memory address; equals pc.
REQ-006 imemAck  input  1  memory has returned imemData this cycle.
REQ-007 imemData  input  32  instruction word, valid when imemAck=1.
REQ-008 stall  input  1  downstream not ready; hold the current instruction.
REQ-009 branch, PC_Source, contJAL, contJALR  input  1 each  control-unit decisions for the issued instruction.
REQ-010 branchCond  input  1  datapath comparison result (1 = branch condition met).
REQ-011 imm  input  32  sign-extended immediate from the extender.
REQ-012 rs1Data  input  32  register-file read port 1.
REQ-013 opcode 7, funct3 3, funct7 7, rd 5, rs1 5, rs2 5  output  decoded fields of IR (IR[6:0], [14:12], [31:25], [11:7], [19:15], [24:20]).
REQ-014 instrValid  output  1  IR holds an issued instruction.
REQ-015 pc  output  32  address of the instruction in IR.
REQ-016 pcPlus4  output  32  pc+4, link value for JAL/JALR.
REQ-017 misaligned  output  1  sticky fault: a computed next PC had bits [1:0] != 0.

Function
REQ-018 States: IDLE, REQ, ISSUE, HALT; a registered instruction register IR holds the fetched word.
REQ-019 IDLE: all outputs inactive; unconditional transition to REQ on the next edge.
REQ-020 REQ: imemReq=1, imemAddr=pc; on imemAck=1, IR<=imemData and state->ISSUE; otherwise stay in REQ (unbounded wait).
REQ-021 ISSUE: instrValid=1, imemReq=0; with stall=1 hold pc, IR and state; with stall=0, pc<=nextPC and state->REQ.
REQ-022 nextPC priority, highest first: PC_Source&contJAL -> pc+imm; PC_Source&contJALR -> (rs1Data+imm)&32'hFFFF_FFFE; branch&branchCond -> pc+imm; else pc+4.
REQ-023 JAL asserts both contJAL and contJALR; contJAL priority SHALL make JAL target pc+imm.
REQ-024 Adds are 32-bit modulo 2^32; wrap from 32'hFFFF_FFFC +4 gives 32'h0000_0000 with no fault.
REQ-025 If nextPC[1:0] != 2'b00 when leaving ISSUE, pc is not updated, misaligned<=1 and state->HALT.
REQ-026 HALT: imemReq=0, instrValid=0, misaligned=1; exit only through reset.
REQ-027 imemAck is ignored in IDLE, ISSUE and HALT.
REQ-028 Minimum throughput: one instruction per 2 cycles (ack in the same cycle as the request).
REQ-029 Field outputs are combinational from IR; pcPlus4 is combinational pc+4.

Reset
REQ-030 With rst_n=0 at an edge: state<=IDLE, pc<=RESET_PC, IR<=32'h0000_0013 (NOP), misaligned<=0.
REQ-031 During and after reset until the first REQ: imemReq=0 and instrValid=0.
REQ-032 Reset asserted in REQ or ISSUE aborts the fetch; an imemAck in the same cycle is discarded.

Verification
REQ-033 Reset release, imemAck=1 immediately, imemData=32'h0010_0093 -> imemReq at cycle 1 with imemAddr=0; ISSUE at cycle 2 with opcode=7'b0010011, rd=1, instrValid=1; next imemAddr=4.
REQ-034 Ack delayed 3 cycles, then stall=1 for 2 cycles in ISSUE -> imemReq held 4 cycles; pc and IR unchanged while stalled; fetch resumes at pc+4.
REQ-035 pc=32'h10, JAL (PC_Source=1, contJAL=1, contJALR=1), imm=32'h20 -> next imemAddr=32'h30, pcPlus4=32'h14 during ISSUE.
REQ-036 JALR with rs1Data=32'h101, imm=0 -> imemAddr=32'h100; rs1Data=32'h102 -> misaligned=1, HALT, imemReq stays 0 until rst_n=0.
REQ-037 BNE at pc=32'h40, imm=32'hFFFF_FFF8: branchCond=1 -> next 32'h38; branchCond=0 -> next 32'h44.
REQ-038 rst_n=0 while in REQ with imemAck=1 -> IR stays NOP, pc=RESET_PC, instrValid=0.
